// File: rtl/io_pkg.sv
// Board-level constants for the DE2 switch bank and the debounce defaults
// derived from them.
package io_pkg;

    localparam int DE2_NUM_SW           = 17;
    localparam int DE2_CLK_HZ           = 50_000_000;
    // One sample tick per millisecond of the board clock.
    localparam int DEFAULT_TICK_DIV     = DE2_CLK_HZ / 1000;
    localparam int DEFAULT_STABLE_TICKS = 10;

    // Width of a counter that must be able to hold the value n.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sw_debounce_ch.sv
// One switch channel: two-flop synchroniser, tick-driven stability counter,
// debounced level, rise/fall pulses and a sticky write-1-to-clear event flag.
module sw_debounce_ch
    import io_pkg::*;
#(
    parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_tick,
    input  logic i_sw,
    input  logic i_evt_clr,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall,
    output logic o_evt
);

    localparam int              CW       = $clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_TICKS - 1);

    logic          meta_q;
    logic          sync_q;
    logic [CW-1:0] cnt_q;

    // NOTE: every flop here, including the synchroniser, is cleared by reset so
    // a partially accumulated count can never survive into the next run.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            cnt_q    <= '0;
            o_stable <= 1'b0;
            o_rise   <= 1'b0;
            o_fall   <= 1'b0;
            o_evt    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every right-hand
            // side below sees the pre-edge value of the register it reads.
            meta_q <= i_sw;
            sync_q <= meta_q;
            o_rise <= 1'b0;
            o_fall <= 1'b0;

            // Any return to the accepted level restarts the window.
            if (sync_q == o_stable) begin
                cnt_q <= '0;
            end else if (i_tick) begin
                if (cnt_q == CNT_LAST) begin
                    o_stable <= sync_q;
                    cnt_q    <= '0;
                    o_rise   <= sync_q;
                    o_fall   <= ~sync_q;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end

            // A new event beats a simultaneous clear.
            if (o_rise || o_fall) begin
                o_evt <= 1'b1;
            end else if (i_evt_clr) begin
                o_evt <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/io_sw_debounce.sv
// Switch-input conditioner: shared sample-tick prescaler feeding one debounce
// channel per switch, plus the event summary and the 32-bit CPU switch word.
module io_sw_debounce
    import io_pkg::*;
#(
    parameter int NUM_SW       = DE2_NUM_SW,
    parameter int TICK_DIV     = DEFAULT_TICK_DIV,
    parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NUM_SW-1:0] i_sw,
    input  logic [NUM_SW-1:0] i_evt_clr,
    output logic [NUM_SW-1:0] o_sw_stable,
    output logic [NUM_SW-1:0] o_sw_rise,
    output logic [NUM_SW-1:0] o_sw_fall,
    output logic [NUM_SW-1:0] o_sw_evt,
    output logic              o_any_evt,
    output logic [31:0]       o_io_sw
);

    if (NUM_SW < 1 || NUM_SW > 32) begin : g_chk_num_sw
        $fatal(1, "io_sw_debounce: NUM_SW must be in 1..32");
    end
    if (TICK_DIV < 2) begin : g_chk_tick_div
        $fatal(1, "io_sw_debounce: TICK_DIV must be at least 2");
    end
    if (STABLE_TICKS < 1) begin : g_chk_stable_ticks
        $fatal(1, "io_sw_debounce: STABLE_TICKS must be at least 1");
    end

    localparam int            PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_q;
    logic          tick;

    // Free-running; input activity never realigns the tick phase.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pre_q <= '0;
        end else if (pre_q == PRE_LAST) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PW'(1);
        end
    end

    assign tick = (pre_q == PRE_LAST);

    for (genvar g = 0; g < NUM_SW; g++) begin : g_ch
        sw_debounce_ch #(
            .STABLE_TICKS (STABLE_TICKS)
        ) u_ch (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_tick    (tick),
            .i_sw      (i_sw[g]),
            .i_evt_clr (i_evt_clr[g]),
            .o_stable  (o_sw_stable[g]),
            .o_rise    (o_sw_rise[g]),
            .o_fall    (o_sw_fall[g]),
            .o_evt     (o_sw_evt[g])
        );
    end

    assign o_any_evt = |o_sw_evt;
    assign o_io_sw   = 32'(o_sw_stable);

endmodule

// File: tb/tb_io_sw_debounce.sv
// Self-checking bench: a 4-channel instance (TICK_DIV=4, STABLE_TICKS=3) for
// the directed cases and a 17-channel instance for the random bounce run.
module tb_io_sw_debounce;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [3:0]  sw, clr, stable, rise, fall, evt;
    logic        any_evt;
    logic [31:0] io_sw;

    logic [16:0] sw_w, clr_w, stable_w, rise_w, fall_w, evt_w;
    logic        any_evt_w;
    logic [31:0] io_sw_w;

    int n_cmp = 0;
    int n_err = 0;
    int rcnt[4];
    int fcnt[4];
    int overlap = 0;

    typedef struct {
        logic [3:0] sw;
        logic [3:0] clr;
        int         cyc;
        logic [3:0] stable;
        logic [3:0] evt;
        logic [3:0] rise;
        logic [3:0] fall;
    } vec_t;

    typedef struct {
        int   ch;
        logic rise;
    } wexp_t;

    vec_t  vecs[10];
    vec_t  sb_q[$];
    wexp_t exp_q[$];

    always #5 clk = ~clk;

    io_sw_debounce #(.NUM_SW(4), .TICK_DIV(4), .STABLE_TICKS(3)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_sw        (sw),
        .i_evt_clr   (clr),
        .o_sw_stable (stable),
        .o_sw_rise   (rise),
        .o_sw_fall   (fall),
        .o_sw_evt    (evt),
        .o_any_evt   (any_evt),
        .o_io_sw     (io_sw)
    );

    io_sw_debounce #(.NUM_SW(17), .TICK_DIV(50), .STABLE_TICKS(10)) dut_w (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_sw        (sw_w),
        .i_evt_clr   (clr_w),
        .o_sw_stable (stable_w),
        .o_sw_rise   (rise_w),
        .o_sw_fall   (fall_w),
        .o_sw_evt    (evt_w),
        .o_any_evt   (any_evt_w),
        .o_io_sw     (io_sw_w)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance n cycles, sampling on the falling edge and tallying pulses.
    task automatic cyc(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                rcnt[i] += int'(rise[i]);
                fcnt[i] += int'(fall[i]);
            end
            if ((rise & fall) != 4'h0) overlap++;
        end
    endtask

    task automatic wait_for(input logic [3:0] mask, input logic [3:0] val,
                            input int max, output int lat);
        lat = max + 1;
        for (int k = 1; k <= max; k++) begin
            cyc(1);
            if ((stable & mask) == (val & mask)) begin
                lat = k;
                break;
            end
        end
    endtask

    // Scoreboard for the wide instance: each observed pulse must match an
    // outstanding expected change.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 17; i++) begin
                if (rise_w[i] || fall_w[i]) begin
                    automatic bit found = 1'b0;
                    for (int j = 0; j < exp_q.size(); j++) begin
                        if (!found && exp_q[j].ch == i && exp_q[j].rise == rise_w[i]) begin
                            exp_q.delete(j);
                            found = 1'b1;
                        end
                    end
                    check($sformatf("w_pulse_ch%0d", i), 32'(found), 32'd1);
                end
            end
        end
    end

    initial begin
        int   lat;
        vec_t v;
        int   r0[4];
        int   f0[4];
        logic [16:0] cur, tgt;

        vecs[0] = '{4'hF, 4'hF, 4,  4'hF, 4'h0, 4'h0, 4'h0};
        vecs[1] = '{4'hE, 4'h0, 6,  4'hF, 4'h0, 4'h0, 4'h0};
        vecs[2] = '{4'hF, 4'h0, 20, 4'hF, 4'h0, 4'h0, 4'h0};
        vecs[3] = '{4'hB, 4'h0, 20, 4'hB, 4'h4, 4'h0, 4'h4};
        vecs[4] = '{4'hF, 4'h0, 20, 4'hF, 4'h4, 4'h4, 4'h0};
        vecs[5] = '{4'hF, 4'h4, 3,  4'hF, 4'h0, 4'h0, 4'h0};
        vecs[6] = '{4'h0, 4'h0, 20, 4'h0, 4'hF, 4'h0, 4'hF};
        vecs[7] = '{4'h5, 4'h2, 20, 4'h5, 4'hD, 4'h5, 4'h0};
        vecs[8] = '{4'h7, 4'h0, 6,  4'h5, 4'hD, 4'h0, 4'h0};
        vecs[9] = '{4'h5, 4'h0, 20, 4'h5, 4'hD, 4'h0, 4'h0};

        for (int i = 0; i < 4; i++) begin
            rcnt[i] = 0;
            fcnt[i] = 0;
        end

        // Reset with all switches high.
        rst_n = 1'b0;
        sw    = 4'hF;
        clr   = 4'h0;
        sw_w  = '0;
        clr_w = '0;
        cyc(3);
        check("rst_stable", 32'(stable), 32'h0);
        check("rst_rise",   32'(rise),   32'h0);
        check("rst_fall",   32'(fall),   32'h0);
        check("rst_evt",    32'(evt),    32'h0);
        check("rst_any",    32'(any_evt), 32'h0);
        check("rst_io_sw",  io_sw,       32'h0);
        rst_n = 1'b1;
        wait_for(4'hF, 4'hF, 20, lat);
        check("rst_lat_ok", 32'(lat >= 11 && lat <= 14), 32'd1);
        check("rst_rise_pulse", 32'(rise), 32'hF);
        check("rst_fall_quiet", 32'(fall), 32'h0);
        check("rst_evt_lag",    32'(evt),  32'h0);
        cyc(1);
        check("rst_rise_end", 32'(rise),    32'h0);
        check("rst_evt_set",  32'(evt),     32'hF);
        check("rst_any_set",  32'(any_evt), 32'h1);
        check("rst_io_sw_f",  io_sw,        32'h0000000F);

        // Table-driven vectors through the scoreboard queue.
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < 4; i++) begin
                r0[i] = rcnt[i];
                f0[i] = fcnt[i];
            end
            sw  = vecs[n].sw;
            clr = vecs[n].clr;
            sb_q.push_back(vecs[n]);
            cyc(1);
            clr = 4'h0;
            cyc(vecs[n].cyc - 1);
            v = sb_q.pop_front();
            check($sformatf("v%0d_stable", n), 32'(stable), 32'(v.stable));
            check($sformatf("v%0d_evt", n),    32'(evt),    32'(v.evt));
            check($sformatf("v%0d_any", n),    32'(any_evt), 32'(|v.evt));
            check($sformatf("v%0d_io_sw", n),  io_sw,       32'(v.stable));
            for (int i = 0; i < 4; i++) begin
                check($sformatf("v%0d_rise_cnt%0d", n, i), 32'(rcnt[i] - r0[i]), 32'(v.rise[i]));
                check($sformatf("v%0d_fall_cnt%0d", n, i), 32'(fcnt[i] - f0[i]), 32'(v.fall[i]));
            end
        end

        // Clean rise on ch3 with latency and pulse-timing checks.
        clr = 4'hF;
        cyc(1);
        clr = 4'h0;
        check("tog_evt_cleared", 32'(evt), 32'h0);
        sw = 4'hD;
        wait_for(4'h8, 4'h8, 20, lat);
        check("tog_rise_lat_ok", 32'(lat >= 11 && lat <= 14), 32'd1);
        check("tog_rise_pulse",  32'(rise),   32'h8);
        check("tog_others",      32'(stable), 32'hD);
        check("tog_evt_lag",     32'(evt),    32'h0);
        cyc(1);
        check("tog_rise_end", 32'(rise), 32'h0);
        check("tog_evt_set",  32'(evt),  32'h8);

        // Fall on ch2 with the clear landing in the pulse cycle.
        sw  = 4'h9;
        lat = 21;
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            if (fall[2]) begin
                lat = k;
                break;
            end
        end
        check("coin_fall_lat_ok", 32'(lat >= 11 && lat <= 14), 32'd1);
        check("coin_stable",      32'(stable), 32'h9);
        clr = 4'h4;
        cyc(1);
        clr = 4'h0;
        check("coin_set_wins", 32'(evt), 32'hC);
        clr = 4'h4;
        cyc(1);
        clr = 4'h0;
        check("clr_ch2_evt", 32'(evt),     32'h8);
        check("clr_ch2_any", 32'(any_evt), 32'h1);
        clr = 4'h8;
        cyc(1);
        clr = 4'h0;
        check("clr_all_evt", 32'(evt),     32'h0);
        check("clr_all_any", 32'(any_evt), 32'h0);

        // Reset part-way through a debounce window.
        sw = 4'hB;
        cyc(9);
        check("mid_not_yet", 32'(stable), 32'h9);
        rst_n = 1'b0;
        #1;
        check("mid_rst_stable", 32'(stable),  32'h0);
        check("mid_rst_evt",    32'(evt),     32'h0);
        check("mid_rst_any",    32'(any_evt), 32'h0);
        check("mid_rst_io_sw",  io_sw,        32'h0);
        cyc(2);
        rst_n = 1'b1;
        wait_for(4'hF, 4'hB, 20, lat);
        check("mid_full_window", 32'(lat >= 11 && lat <= 14), 32'd1);
        check("mid_rise_pulse",  32'(rise), 32'hB);

        // Wide instance: random bounce bursts, then settle.
        cur = '0;
        for (int r = 0; r < 8; r++) begin
            tgt = 17'($urandom);
            for (int i = 0; i < 17; i++) begin
                if (cur[i] != tgt[i]) exp_q.push_back('{i, tgt[i]});
            end
            for (int c = 0; c < int'($urandom_range(10, 45)); c++) begin
                sw_w = tgt ^ 17'($urandom);
                cyc(1);
            end
            sw_w = tgt;
            cyc(560);
            check($sformatf("w%0d_stable", r),  32'(stable_w), 32'(tgt));
            check($sformatf("w%0d_io_high", r), io_sw_w >> 17, 32'h0);
            check($sformatf("w%0d_io_low", r),  32'(io_sw_w[16:0]), 32'(tgt));
            check($sformatf("w%0d_missing", r), 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            cur = tgt;
        end

        check("rise_fall_exclusive", 32'(overlap), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/io_sw_debounce.md
# io_sw_debounce

Parametrised switch-input conditioner between the board slide switches and the CPU's `i_io_sw` port. It supersedes the plain zero-extending switch assignment. Each channel gets:
- two-flop synchronisation;
- tick-based debouncing;
- rise/fall event pulses;
- a sticky event register that software clears with write-1-to-clear.

The block also presents the debounced vector zero-extended to 32 bits for the single-cycle core's switch input.

## Interface
Parameters:
- `NUM_SW`, default 17: number of switch channels, legal range 1..32.
- `TICK_DIV`, default 50_000: clock cycles per sample tick (1 ms at 50 MHz), minimum 2.
- `STABLE_TICKS`, default 10: consecutive ticks a new level must persist before it is accepted, minimum 1.

Ports:
- One clock; reset is asynchronous and active-low. They are the first two ports below.
- `i_clk`, in, 1: system clock (CLOCK_50).
- `i_rst_n`, in, 1: asynchronous active-low reset.
- `i_sw`, in, `NUM_SW`: raw asynchronous switch levels.
- `i_evt_clr`, in, `NUM_SW`: write-1-to-clear strobe for the sticky event bits.
- `o_sw_stable`, out, `NUM_SW`: debounced switch levels.
- `o_sw_rise`, out, `NUM_SW`: one-cycle pulse when a channel's stable level goes 0→1.
- `o_sw_fall`, out, `NUM_SW`: one-cycle pulse when a channel's stable level goes 1→0.
- `o_sw_evt`, out, `NUM_SW`: sticky "channel changed" flags.
- `o_any_evt`, out, 1: OR-reduction of `o_sw_evt`.
- `o_io_sw`, out, 32: `o_sw_stable` zero-extended to 32 bits, for the CPU switch port.

## Operation
- **Synchroniser:** two flops per channel. The second flop's output is `sync`.
- **Prescaler:** one shared counter runs 0..`TICK_DIV`-1 and wraps. It raises `tick` for one cycle when the count equals `TICK_DIV`-1. Its width is `$clog2(TICK_DIV)`.
- **Per-channel counter:** width is `$clog2(STABLE_TICKS+1)`.
  - When `sync` equals `stable`, the counter clears to 0 on every cycle, whether or not `tick` is high.
  - When `sync` differs from `stable` and `tick` is high, the counter increments.
  - On the tick that would make the count reach `STABLE_TICKS`, three things happen in that same edge: `stable` takes the value of `sync`, the counter clears, and the rise or fall pulse is registered.
  - A glitch shorter than one tick period never changes `stable`. Any return to the old level restarts the count.
- **Event pulses:** `o_sw_rise` and `o_sw_fall` are registered. They are high in exactly the cycle in which the new `o_sw_stable` value is first visible. The two are never high together on the same channel.
- **Sticky events:**
  - `evt[i]` sets on `rise[i]` or `fall[i]`.
  - `evt[i]` clears when `i_evt_clr[i]` is 1.
  - If set and clear occur in the same cycle, set wins.
- **Outputs:** `o_any_evt` is combinational from `evt`. `o_io_sw[31:NUM_SW]` is always 0.
- **Reset values:** all flops clear to 0 (synchronisers, prescaler, counters, `stable`, pulses, `evt`), so every output is 0 during reset.
  - A switch held at 1 through reset release debounces normally afterwards and produces a rise pulse.
  - Reset asserted mid-debounce discards the partial count.

## Timing
- Latency from a clean edge on `i_sw` to `o_sw_stable` is between (`STABLE_TICKS`-1)·`TICK_DIV`+3 and `STABLE_TICKS`·`TICK_DIV`+2 cycles. The uncertainty comes from tick phase.
- The rise/fall pulse width is exactly one cycle. `o_sw_evt` is visible in the cycle after the pulse.
- `i_evt_clr` takes effect at the next edge. `o_sw_evt` reads 0 in the following cycle unless a new event coincides with the clear.
- All channels share one tick, so simultaneous toggles on several channels update in the same cycle.
- The prescaler free-runs from reset and is not realigned by input activity.

## Structure
- **Package `io_pkg`:** holds `DE2_NUM_SW` (17), `DE2_CLK_HZ` (50_000_000), `DEFAULT_TICK_DIV` and `DEFAULT_STABLE_TICKS`. The top-level parameter defaults reference these.
- **Sub-module `sw_debounce_ch`:** one channel, containing the synchroniser, counter, stable flop, rise/fall flops and evt flop. It takes `tick` as an input and is instantiated `NUM_SW` times in a generate loop.
- **Top level:** keeps the shared prescaler, `o_any_evt` and the `o_io_sw` packing.
- Elaboration-time asserts enforce `NUM_SW` ≤ 32, `TICK_DIV` ≥ 2 and `STABLE_TICKS` ≥ 1.

## Test plan
Run with `NUM_SW`=4, `TICK_DIV`=4 and `STABLE_TICKS`=3 unless noted.

1. **Reset:** assert `i_rst_n`=0 with `i_sw`=4'hF → all outputs 0. Release → after ≤14 cycles, `o_sw_stable`=4'hF, a 1-cycle `o_sw_rise`=4'hF, then `o_sw_evt`=4'hF, `o_any_evt`=1 and `o_io_sw`=32'h0000000F.
2. **Glitch rejection:** `i_sw[0]` pulses high for 6 cycles, then returns low → `o_sw_stable`, `o_sw_rise` and `o_sw_evt` all stay 0.
3. **Clean toggle on ch2:** drive 0→1, hold 20 cycles, then drive 1→0 → `stable[2]` rises within 11..14 cycles with one `rise[2]` pulse. It later falls with one `fall[2]` pulse. Other channels stay unchanged.
4. **Sticky clear:**
   - After scenario 3, `i_evt_clr`=4'b0100 for 1 cycle → `o_sw_evt[2]`=0 and `o_any_evt`=0.
   - A repeat with the clear coinciding with `fall[2]` → `evt[2]` stays 1.
5. **Mid-debounce reset:** change `i_sw[1]` to 1, then assert reset after 2 ticks → the counter is cleared and all outputs are 0. After release, `stable[1]` rises only after a full `STABLE_TICKS` window.
6. **Full-width run:** `NUM_SW`=17, `TICK_DIV`=50 and `STABLE_TICKS`=10, with random bounce bursts shorter than 50 cycles and then settle → `o_sw_stable` matches the settled `i_sw`. Exactly one rise or fall pulse occurs per net change, and `o_io_sw[31:17]`=0.
